// File: rtl/sram_uart_pkg.sv
// Shared op codes, command-byte layout and FSM states for the UART SRAM/DPU host.
package sram_uart_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_DPU = 2'b10,
    OP_BAD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_e;

  localparam int CMD_DPU_BIT = 7;
  localparam int CMD_RD_BIT  = 5;
  localparam int ADDR_W      = 5;
  localparam int DPU_W       = 7;

  // DPU commands own bits [6:0]; memory ops carry the address plus a read flag.
  function automatic logic [7:0] cmd_byte(op_e op, logic [ADDR_W-1:0] addr,
                                          logic [DPU_W-1:0] dpu);
    logic [7:0] b;
    b = '0;
    if (op == OP_DPU) begin
      b[CMD_DPU_BIT]  = 1'b1;
      b[DPU_W-1:0]    = dpu;
    end else begin
      b[ADDR_W-1:0]   = addr;
      b[CMD_RD_BIT]   = (op == OP_RD);
    end
    return b;
  endfunction

endpackage

// File: rtl/sram_uart_host.sv
// Word-level request initiator that serialises requests onto the controller byte protocol.
// Optional read-response timeout: define SRAM_UART_HOST_TIMEOUT_EN.
module sram_uart_host
  import sram_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [6:0]  req_dpu_cmd,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data
);

  if ((64'd1 << TO_W) < 64'(TIMEOUT_CYCLES)) begin : g_to_w_check
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e      state_q;
  op_e         op_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  cnt_q;
  logic        req_ready_q, rx_ready_q, tx_valid_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [7:0]  tx_data_q;
  logic [31:0] rsp_data_q;

  logic [1:0]  cnt_inc;
  logic [31:0] rdata_shift;

  assign cnt_inc     = cnt_q + 2'd1;
  assign rdata_shift = {rx_data, rdata_q[31:8]};

`ifdef SRAM_UART_HOST_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q;
`endif

  // Every output is a register updated together with the state it belongs to.
  // NOTE: reset is sampled on the clock edge here, so it sits inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WR;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SRAM_UART_HOST_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= op_e'(req_op);
            wdata_q     <= req_wdata;
            rdata_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            if (op_e'(req_op) == OP_BAD) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q    <= ST_CMD;
              tx_valid_q <= 1'b1;
              tx_data_q  <= cmd_byte(op_e'(req_op), req_addr, req_dpu_cmd);
            end
          end else begin
            req_ready_q <= 1'b1;
            rx_ready_q  <= 1'b1;
          end
        end

        ST_CMD: begin
          if (tx_ready) begin
            case (op_q)
              OP_WR: begin
                state_q   <= ST_WDATA;
                tx_data_q <= wdata_q[7:0];
              end
              OP_RD: begin
                state_q    <= ST_RDATA;
                tx_valid_q <= 1'b0;
                rx_ready_q <= 1'b1;
`ifdef SRAM_UART_HOST_TIMEOUT_EN
                to_q       <= '0;
`endif
              end
              default: begin
                state_q     <= ST_DONE;
                tx_valid_q  <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b0;
              end
            endcase
          end
        end

        ST_WDATA: begin
          if (tx_ready) begin
            if (cnt_q == 2'd3) begin
              state_q     <= ST_DONE;
              cnt_q       <= '0;
              tx_valid_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b0;
            end else begin
              cnt_q     <= cnt_inc;
              tx_data_q <= wdata_q[{cnt_inc, 3'b000} +: 8];
            end
          end
        end

        ST_RDATA: begin
          if (rx_valid) begin
            rdata_q <= rdata_shift;
            cnt_q   <= cnt_inc;
`ifdef SRAM_UART_HOST_TIMEOUT_EN
            to_q    <= '0;
`endif
            if (cnt_q == 2'd3) begin
              state_q     <= ST_DONE;
              rx_ready_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rdata_shift;
              rsp_err_q   <= 1'b0;
            end
          end
`ifdef SRAM_UART_HOST_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            state_q     <= ST_DONE;
            rx_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rdata_q;
            rsp_err_q   <= 1'b1;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
`endif
        end

        ST_DONE: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          rx_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule
